// File: rtl/sid_bus_pkg.sv
// sid_bus_pkg: shared definitions for the SID register-write bus.
//   - command word layout (opcode bit, address/data/delay fields)
//   - SID register address constants used by the filter/voice decoders
//   - helpers that build WRITE and DELAY command words
package sid_bus_pkg;

  localparam int CMD_W       = 16;
  localparam int OP_BIT      = 15;  // 0 = WRITE, 1 = DELAY
  localparam int ADDR_HI     = 12;
  localparam int ADDR_LO     = 8;
  localparam int DATA_HI     = 7;
  localparam int DATA_LO     = 0;
  localparam int DLY_FIELD_W = 14;  // delay count lives in [13:0]

  localparam logic [4:0] FC_LO    = 5'h15;
  localparam logic [4:0] FC_HI    = 5'h16;
  localparam logic [4:0] RES_FILT = 5'h17;
  localparam logic [4:0] MODE_VOL = 5'h18;

  function automatic logic [CMD_W-1:0] mk_write(input logic [4:0] addr,
                                                input logic [7:0] data);
    return {1'b0, 2'b00, addr, data};
  endfunction

  function automatic logic [CMD_W-1:0] mk_delay(input logic [DLY_FIELD_W-1:0] n);
    return {1'b1, 1'b0, n};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: register-array show-ahead FIFO with occupancy output.
//   clk_i, rst_i   clock, synchronous active-high reset (empties the FIFO)
//   push_i, din_i  write side; ignored when full
//   pop_i, dout_o  read side; dout_o is the head entry, pop ignored when empty
//   level_o        number of stored entries (0..DEPTH)
//   full_o/empty_o occupancy flags
module sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/sid_bus_writer.sv
// sid_bus_writer: buffers host commands and replays them as single-cycle
// register write strobes on the SID WE/Addr/Data bus. DELAY commands hold
// the stream for N SID ticks (clkEn pulses).
//   clk, rst            clock, synchronous active-high reset
//   clkEn               SID tick used to count delays
//   iCmd/iCmdValid      command input; accepted when oCmdReady
//   oCmdReady           FIFO not full
//   oWE/oAddr/oData     registered write strobe, address, data
//   oLevel              FIFO occupancy
//   oBusy               anything queued, waiting, or strobing
module sid_bus_writer
  import sid_bus_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  parameter  int DELAY_W    = 14,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEn,
  input  logic [15:0]      iCmd,
  input  logic             iCmdValid,
  output logic             oCmdReady,
  output logic             oWE,
  output logic [4:0]       oAddr,
  output logic [7:0]       oData,
  output logic [LVL_W-1:0] oLevel,
  output logic             oBusy
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [15:0]        head;
  logic               full, empty, pop;
  logic [LVL_W-1:0]   level;

  logic [0:0]         state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [4:0]         addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic [DELAY_W-1:0] dly;
  logic               unused_rsvd;

  // Head is only consumed while running; WAIT stalls the queue.
  assign pop = (state_q == S_RUN) & ~empty;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (iCmdValid),
    .din_i   (iCmd),
    .pop_i   (pop),
    .dout_o  (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign dly         = head[DELAY_W-1:0];
  assign unused_rsvd = ^head[14:13];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (state_q == S_RUN) begin
      if (pop) begin
        if (!head[OP_BIT]) begin
          we_d   = 1'b1;
          addr_d = head[ADDR_HI:ADDR_LO];
          data_d = head[DATA_HI:DATA_LO];
        end else if (dly != '0) begin
          // DELAY 0 just burns the pop slot and stays in RUN.
          cnt_d   = dly;
          state_d = S_WAIT;
        end
      end
    end else if (clkEn) begin
      // Ticks are only counted from the edge after the DELAY was popped.
      cnt_d = cnt_q - DELAY_W'(1);
      if (cnt_q == DELAY_W'(1)) state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign oCmdReady = ~full;
  assign oWE       = we_q;
  assign oAddr     = addr_q;
  assign oData     = data_q;
  assign oLevel    = level;
  assign oBusy     = (level != '0) | (state_q == S_WAIT) | we_q;

endmodule

// File: tb/tb_sid_bus_writer.sv
// tb_sid_bus_writer: randomized + directed stimulus with a transaction-level
// reference model. Each accepted command is scheduled (pop edge, strobe cycle,
// busy span) from the command rules and a pre-planned clkEn schedule; a
// monitor compares every cycle against that schedule.
module tb_sid_bus_writer;
  import sid_bus_pkg::*;

  localparam int MAXC = 20000;

  logic        clk = 1'b0;
  logic        rst, clkEn, iCmdValid;
  logic [15:0] iCmd;
  logic        oCmdReady, oWE, oBusy;
  logic [4:0]  oAddr;
  logic [7:0]  oData;
  logic [4:0]  oLevel;

  sid_bus_writer #(.FIFO_DEPTH(16), .DELAY_W(14)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .iCmd(iCmd), .iCmdValid(iCmdValid),
    .oCmdReady(oCmdReady), .oWE(oWE), .oAddr(oAddr), .oData(oData),
    .oLevel(oLevel), .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; edge k is the k-th posedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit rst_at_edge = 1'b0;
  always @(posedge clk) rst_at_edge <= rst;

  // Planned clkEn value for each edge.
  bit cen [MAXC];
  always @(negedge clk) clkEn = (cyc + 1 < MAXC) ? cen[cyc+1] : 1'b0;

  typedef struct { int emit; logic [4:0] a; logic [7:0] d; } wr_t;
  typedef struct { int p; int pop; int fin; } cmd_t;

  wr_t  exp_q[$];
  cmd_t cmds[$];
  int   t_free = 0;
  int   checks = 0, errors = 0;
  logic [4:0] last_a = '0;
  logic [7:0] last_d = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // Schedule a command accepted at edge p.
  task automatic model_push(input logic [15:0] c, input int p);
    int pop, fin, k, n, seen;
    pop = (p + 1 > t_free) ? p + 1 : t_free;
    if (!c[15]) begin
      exp_q.push_back('{pop, c[12:8], c[7:0]});
      fin    = pop;          // strobe visible in the cycle after the pop edge
      t_free = pop + 1;
    end else begin
      n = int'(c[13:0]);
      if (n == 0) begin
        fin    = pop - 1;
        t_free = pop + 1;
      end else begin
        k = pop; seen = 0;
        while (seen < n && k < MAXC - 1) begin
          k++;
          if (cen[k]) seen++;
        end
        fin    = k - 1;      // waiting through the cycle before edge k
        t_free = k + 1;
      end
    end
    cmds.push_back('{p, pop, fin});
  endtask

  // Reset at edge r: everything queued or in flight vanishes.
  task automatic model_reset(input int r);
    foreach (cmds[i]) begin
      if (cmds[i].pop > r)     cmds[i].pop = r;
      if (cmds[i].fin > r - 1) cmds[i].fin = r - 1;
    end
    while (exp_q.size() > 0 && exp_q[$].emit >= r) void'(exp_q.pop_back());
    t_free = r + 1;
  endtask

  int  lvl;
  bit  busy;
  wr_t w;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      lvl = 0; busy = 1'b0;
      foreach (cmds[i]) begin
        if (cmds[i].p <= cyc && cyc < cmds[i].pop) lvl++;
        if (cmds[i].p <= cyc && cyc <= cmds[i].fin) busy = 1'b1;
      end
      if (rst_at_edge) begin last_a = '0; last_d = '0; end
      if (exp_q.size() > 0 && exp_q[0].emit == cyc) begin
        w = exp_q.pop_front();
        chk("we_high", 32'(oWE), 32'd1);
        chk("addr", 32'(oAddr), 32'(w.a));
        chk("data", 32'(oData), 32'(w.d));
        last_a = w.a; last_d = w.d;
      end else begin
        chk("we_low", 32'(oWE), 32'd0);
        chk("addr_hold", 32'(oAddr), 32'(last_a));
        chk("data_hold", 32'(oData), 32'(last_d));
        if (exp_q.size() > 0 && exp_q[0].emit < cyc) begin
          errors++;
          $display("FAIL missed_write cyc=%0d got=none exp=emit@%0d", cyc, exp_q[0].emit);
          void'(exp_q.pop_front());
        end
      end
      chk("level", 32'(oLevel), 32'(lvl));
      chk("ready", 32'(oCmdReady), 32'(lvl != 16));
      chk("busy", 32'(oBusy), 32'(busy));
      while (cmds.size() > 0 && cmds[0].fin < cyc && cmds[0].pop <= cyc)
        void'(cmds.pop_front());
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] c);
    int n = 0;
    iCmd = c; iCmdValid = 1'b1;
    while (!oCmdReady && n < 5000) begin tick(); n++; end
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL send_timeout cyc=%0d got=ready0 exp=ready1", cyc);
    end else begin
      model_push(c, cyc + 1);
      tick();
    end
    iCmdValid = 1'b0;
  endtask

  task automatic do_reset(input int len);
    rst = 1'b1;
    for (int i = 1; i <= len; i++) model_reset(cyc + i);
    repeat (len) tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || cmds.size() != 0) && n < 4000) begin tick(); n++; end
    checks++;
    if (n >= 4000) begin
      errors++;
      $display("FAIL drain_timeout cyc=%0d got=pending%0d exp=0", cyc, exp_q.size());
    end
    repeat (3) tick();
  endtask

  logic [15:0] c;
  initial begin
    rst = 1'b1; iCmdValid = 1'b0; iCmd = '0; clkEn = 1'b0;
    for (int i = 0; i < MAXC; i++) cen[i] = (i % 10 == 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // single write into an idle block
    send(mk_write(FC_LO, 8'h07));
    drain();

    // back-to-back writes
    send(mk_write(FC_LO, 8'h03));
    send(mk_write(FC_HI, 8'hA5));
    send(mk_write(RES_FILT, 8'hF1));
    send(mk_write(MODE_VOL, 8'h1F));
    drain();

    // DELAY 3 popped on a clkEn edge (multiple of 10)
    while ((cyc + 3) % 10 != 0) tick();
    send(mk_write(MODE_VOL, 8'h0F));
    send(mk_delay(14'd3));
    send(mk_write(MODE_VOL, 8'h00));
    drain();

    // long delay with 20 writes behind it: fills the FIFO, backpressure
    send(mk_delay(14'd100));
    for (int i = 0; i < 20; i++) send(mk_write(5'($urandom_range(0, 31)), 8'($urandom)));
    drain();

    // WRITE, DELAY 0, WRITE
    send(mk_write(FC_LO, 8'h11));
    send(mk_delay(14'd0));
    send(mk_write(FC_HI, 8'h22));
    drain();

    // reset in the middle of a wait with queued writes
    send(mk_delay(14'd50));
    for (int i = 0; i < 5; i++) send(mk_write(MODE_VOL, 8'(i)));
    repeat (4) tick();
    do_reset(1);
    repeat (30) tick();
    drain();

    // randomized: random clkEn, random commands/gaps, reserved bits set
    for (int i = cyc + 2; i < MAXC; i++) cen[i] = ($urandom_range(0, 2) == 0);
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 99) == 0) do_reset(1 + $urandom_range(0, 1));
      if ($urandom_range(0, 9) < 7) begin
        c = mk_write(5'($urandom_range(0, 31)), 8'($urandom));
        c[14:13] = 2'($urandom);
      end else begin
        c = mk_delay(14'($urandom_range(0, 6)));
        c[14] = 1'($urandom);
      end
      send(c);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sid_bus_writer.md
# sid_bus_writer

Register-write initiator for the SID register bus: accepts a stream of 16-bit commands from the host side (MCU/SPI/UART bridge) through a valid/ready handshake, buffers them in a small FIFO, and replays them as single-cycle write strobes on the shared `WE/Addr/Data` bus consumed by the voice and filter register decoders. Delay commands pause the stream for a number of SID ticks (`clkEn` pulses), so register dumps play back with correct per-frame timing.

## Interface
- `FIFO_DEPTH`, 16: command FIFO entries; power of two, ≥ 2.
- `DELAY_W`, 14: delay counter width; must be ≤ 14, the width of the command delay field.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `clkEn`  in  1  SID tick; the same enable that drives the filter and voices.
- `iCmd`  in  16  command word.
- `iCmdValid`  in  1  `iCmd` is valid.
- `oCmdReady`  out  1  FIFO can accept; equals `level != FIFO_DEPTH`.
- `oWE`  out  1  register write strobe; one cycle per write command.
- `oAddr`  out  5  register address; valid while `oWE` = 1.
- `oData`  out  8  register data; valid while `oWE` = 1.
- `oLevel`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `oBusy`  out  1  `oLevel != 0`, or state = WAIT, or `oWE`.

## Operation
- Command encoding:
  - `iCmd[15]` = 0 is a WRITE: `addr = iCmd[12:8]`, `data = iCmd[7:0]`. Bits 14:13 are reserved and ignored.
  - `iCmd[15]` = 1 is a DELAY: `N = iCmd[13:0]`, truncated to `DELAY_W` bits. Bit 14 is reserved and ignored.
- Push occurs on a clock edge where `iCmdValid & oCmdReady` and `rst` = 0.
- FIFO is show-ahead with no bypass. A command pushed into an empty FIFO can be popped at the next edge at the earliest.
- States: RUN, WAIT.
  - RUN with FIFO non-empty pops the head on each edge.
    - WRITE: registers `oWE`=1, `oAddr`, `oData` for exactly the following cycle. State stays RUN, giving one write per clock when back-to-back.
    - DELAY with N = 0: no-op that consumes the pop slot. State stays RUN.
    - DELAY with N > 0: `cnt` ← N, state ← WAIT.
  - RUN with FIFO empty: `oWE` = 0, no action.
  - WAIT: no pops.
    - Each edge with `clkEn` = 1 decrements `cnt`.
    - On the edge where `clkEn` = 1 and `cnt` = 1, state ← RUN.
    - A `clkEn` coinciding with the pop edge that entered WAIT is not counted.
- Push and pop on the same edge are both honoured; `oLevel` is unchanged.
- Full FIFO: `oCmdReady` = 0. A held `iCmdValid` is not accepted and nothing is dropped. Ready reasserts the cycle after a pop.
- `oAddr`/`oData` hold their last value when `oWE` = 0.
- Reset, including mid-WAIT or with a full FIFO:
  - Next cycle: FIFO empty, `oLevel` = 0, `cnt` = 0, state = RUN, `oWE` = 0, `oAddr` = 0, `oData` = 0, `oBusy` = 0.
  - Pushes on a reset edge are discarded. `oCmdReady` reads 1 during reset, since the level is 0.
  - No queued command survives reset.

## Timing
- Handshake edge E0 into an idle, empty block: pop at E1; `oWE` high in the cycle after E1, i.e. 2 cycles after E0.
- N back-to-back WRITEs already queued produce N consecutive `oWE` cycles, in FIFO order.
- A DELAY of 0 between two WRITEs leaves exactly one `oWE`-low cycle between them.
- DELAY N > 0: the edge consuming the Nth counted `clkEn` is Ek. The next queued WRITE is popped at Ek+1, and its `oWE` is high in the cycle after Ek+1.
- All outputs are registered except `oCmdReady` and `oBusy`, which decode registered state only, with no input-to-output combinational path.

## Structure
- Shared package/include `sid_bus_pkg` holds:
  - command field positions and the opcode bit;
  - SID register address constants, e.g. `FC_LO` = 0x15, `FC_HI` = 0x16, `RES_FILT` = 0x17, `MODE_VOL` = 0x18;
  - a helper to build WRITE and DELAY words for the bench.
- One sub-module: `sync_fifo` (WIDTH, DEPTH), a register-array show-ahead FIFO with level output and synchronous reset.
- The RUN/WAIT FSM and delay counter live in the top module.

## Test plan
- Reset, push WRITE {0x15, 0x07} at E0 → `oWE` high for one cycle at E0+2 with `oAddr` = 0x15, `oData` = 0x07; `oBusy` low the following cycle.
- Push WRITEs 0x15/0x03, 0x16/0xA5, 0x17/0xF1, 0x18/0x1F back-to-back → four consecutive `oWE` cycles, same order and values.
- WRITE 0x18/0x0F, DELAY 3, WRITE 0x18/0x00, with `clkEn` every 10 clocks including on the pop edge → second `oWE` exactly 2 cycles after the 3rd counted `clkEn`; the coincident pulse is not counted.
- DELAY 100 followed by 20 WRITE pushes with `iCmdValid` held → `oCmdReady` = 0 at `oLevel` = 16; all 20 writes emerge in order after the delay; none lost or duplicated.
- WRITE, DELAY 0, WRITE → `oWE` pattern 1, 0, 1.
- Assert `rst` for one cycle mid-WAIT with 5 queued → next cycle `oLevel` = 0, `oWE` = 0, state RUN; no further `oWE` without new pushes.
